hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have ports idRs1 and idRs2, input, 5 bits each: source registers of the instruction in ID.
REQ-004 SHALL have ports idUsesRs1 and idUsesRs2, input, 1 bit each: the ID instruction reads that source.
REQ-005 SHALL have ports exRd (input, 5 bits) and exMemRead (input, 1 bit): destination and load flag of the instruction in EX.
REQ-006 SHALL have ports memBranch and memZero, input, 1 bit each: branch resolution in MEM; taken = memBranch & memZero.
REQ-007 SHALL have ports dmemReq and dmemReady, input, 1 bit each: data-memory access in MEM, and its completion.
REQ-008 SHALL have ports pcEn, ifidEn, idexEn, exmemEn and memwbEn, output, 1 bit each: stage-register load enables.
REQ-009 SHALL have ports ifidFlush, idexFlush and exmemFlush, output, 1 bit each: active-high, zero the control fields of that register at the next edge.
REQ-010 SHALL have ports pcSelBranch, output, 1 bit (PC loads the branch target), and memTimeout, output, 1 bit (sticky error).
REQ-011 SHALL have ports loadUseCnt, branchCnt and memStallCnt, output, 32 bits each: event counters.

Function
REQ-012 SHALL implement the FSM states RUN and MEMWAIT; outputs are combinational from the state and the current inputs.
REQ-013 A memory stall SHALL be (state==RUN & dmemReq & !dmemReady) or (state==MEMWAIT & !dmemReady); during a memory stall all five enables are 0 and all flushes are 0.
REQ-014 On RUN with a memory stall, the next state SHALL be MEMWAIT; MEMWAIT with dmemReady=1 SHALL release all enables in that same cycle and the next state is RUN.
REQ-015 Branch taken, when there is no memory stall, SHALL drive pcSelBranch=1, ifidFlush=1, idexFlush=1 and exmemFlush=1, with all enables 1 (a one-cycle, three-bubble penalty).
REQ-016 A load-use hazard SHALL be exMemRead & exRd!=0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
REQ-017 A load-use hazard with no memory stall and no branch taken SHALL drive pcEn=0, ifidEn=0 and idexFlush=1, with the other enables 1.
REQ-018 Priority SHALL be memory stall > branch taken > load-use; a lower event is suppressed, not queued, and re-evaluates when stalled inputs stay held.
REQ-019 The default case SHALL drive all enables 1, all flushes 0 and pcSelBranch 0.
REQ-020 An 8-bit wait counter SHALL increment on each MEMWAIT cycle with dmemReady=0, clear on leaving MEMWAIT, and saturate at 255.
REQ-021 When the wait counter reaches 255, memTimeout SHALL set and stay 1 until reset; the stall itself continues.

Reset
REQ-022 While rst=0, the outputs SHALL be: state RUN, wait counter 0, memTimeout 0, counters 0, all enables 0, all flushes 1, pcSelBranch 0.
REQ-023 Reset asserted mid-MEMWAIT SHALL abort the wait immediately; after release, the FSM starts in RUN.

Configuration
REQ-024 With HAZARD_CTRL_PERF_EN defined, the counters SHALL count as follows, each wrapping at 2^32:
- loadUseCnt: +1 per cycle REQ-017 applies.
- branchCnt: +1 per cycle REQ-015 applies.
- memStallCnt: +1 per memory-stall cycle.
REQ-025 Without HAZARD_CTRL_PERF_EN, the counter ports SHALL remain and be driven constant 0, with no counter flops.

Structure
REQ-026 Package hazard_pkg SHALL hold the FSM state type, the constant MEM_TIMEOUT_LIMIT=255, and the constant PERF_CNT_W=32.
REQ-027 Sub-module perf_counter (clk, rst, inc, count) SHALL be instantiated three times under HAZARD_CTRL_PERF_EN.

Verification
REQ-028 Load-use: exMemRead=1, exRd=5, idRs1=5, idUsesRs1=1 -> same cycle pcEn=0, ifidEn=0, idexFlush=1, exmemEn=1; loadUseCnt=1 next cycle.
REQ-029 exRd=0 case: same stimulus with exRd=0 and idRs1=0 -> no stall, all enables 1.
REQ-030 Memory wait: dmemReq=1, dmemReady=0 for 3 cycles, then 1 -> enables 0 for 3 cycles, all 1 on the 4th; memStallCnt=3; state back to RUN.
REQ-031 Priority: branch taken together with a load-use and a memory stall -> frozen, no flush; on ready, branch flush wins (pcSelBranch=1, 3 flushes, pcEn=1).
REQ-032 Timeout and reset: dmemReady held 0 for 300 cycles -> memTimeout=1 from MEMWAIT cycle 255; then rst=0 asynchronously -> memTimeout=0, flushes=1 immediately, RUN after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_t;

  localparam logic [7:0] MEM_TIMEOUT_LIMIT = 8'd255;
  localparam int         PERF_CNT_W        = 32;

endpackage

`default_nettype wire

// File: rtl/perf_counter.sv
// ============================================================================
// Module      : perf_counter
// Description : Wrapping event counter, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter
  import hazard_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush controller: memory wait > taken branch > load-use.
//               Define HAZARD_CTRL_PERF_EN to build the event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  idRs1,
  input  logic [4:0]  idRs2,
  input  logic        idUsesRs1,
  input  logic        idUsesRs2,
  input  logic [4:0]  exRd,
  input  logic        exMemRead,
  input  logic        memBranch,
  input  logic        memZero,
  input  logic        dmemReq,
  input  logic        dmemReady,
  output logic        pcEn,
  output logic        ifidEn,
  output logic        idexEn,
  output logic        exmemEn,
  output logic        memwbEn,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        exmemFlush,
  output logic        pcSelBranch,
  output logic        memTimeout,
  output logic [31:0] loadUseCnt,
  output logic [31:0] branchCnt,
  output logic [31:0] memStallCnt
);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_waitCnt;
  logic [7:0] w_waitNext;
  logic       r_timeout;
  logic       w_memStall;
  logic       w_taken;
  logic       w_loadUse;

  assign w_memStall = ((r_state == ST_RUN) && dmemReq && !dmemReady) ||
                      ((r_state == ST_MEMWAIT) && !dmemReady);
  assign w_taken    = memBranch & memZero;
  assign w_loadUse  = exMemRead && (exRd != 5'd0) &&
                      ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));

  always_comb begin
    w_nextState = r_state;
    pcEn        = 1'b1;
    ifidEn      = 1'b1;
    idexEn      = 1'b1;
    exmemEn     = 1'b1;
    memwbEn     = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    exmemFlush  = 1'b0;
    pcSelBranch = 1'b0;
    if (!rst) begin
      // Hold the pipe frozen with bubbles flowing in while reset is asserted.
      w_nextState = ST_RUN;
      {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
      {ifidFlush, idexFlush, exmemFlush}       = 3'b111;
    end else if (w_memStall) begin
      w_nextState = ST_MEMWAIT;
      {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
    end else begin
      w_nextState = ST_RUN;
      if (w_taken) begin
        pcSelBranch = 1'b1;
        {ifidFlush, idexFlush, exmemFlush} = 3'b111;
      end else if (w_loadUse) begin
        pcEn      = 1'b0;
        ifidEn    = 1'b0;
        idexFlush = 1'b1;
      end
    end
  end

  always_comb begin
    w_waitNext = 8'd0;
    if ((r_state == ST_MEMWAIT) && !dmemReady) begin
      w_waitNext = (r_waitCnt == MEM_TIMEOUT_LIMIT) ? r_waitCnt : r_waitCnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_waitCnt <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_waitNext;
      r_timeout <= r_timeout | (w_waitNext == MEM_TIMEOUT_LIMIT);
    end
  end

  assign memTimeout = r_timeout;

`ifdef HAZARD_CTRL_PERF_EN
  logic w_incLoadUse;
  logic w_incBranch;

  assign w_incLoadUse = !w_memStall && !w_taken && w_loadUse;
  assign w_incBranch  = !w_memStall && w_taken;

  perf_counter #(.W(PERF_CNT_W)) u_cnt_loaduse (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_incLoadUse),
    .count (loadUseCnt)
  );

  perf_counter #(.W(PERF_CNT_W)) u_cnt_branch (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_incBranch),
    .count (branchCnt)
  );

  perf_counter #(.W(PERF_CNT_W)) u_cnt_memstall (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_memStall),
    .count (memStallCnt)
  );
`else
  assign loadUseCnt  = 32'd0;
  assign branchCnt   = 32'd0;
  assign memStallCnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  idRs1, idRs2, exRd;
  logic        idUsesRs1, idUsesRs2, exMemRead;
  logic        memBranch, memZero, dmemReq, dmemReady;
  logic        pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic        ifidFlush, idexFlush, exmemFlush, pcSelBranch, memTimeout;
  logic [31:0] loadUseCnt, branchCnt, memStallCnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_wait;
  int          m_wcnt;
  bit          m_to;
  int unsigned m_lu, m_br, m_ms;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRd(exRd), .exMemRead(exMemRead),
    .memBranch(memBranch), .memZero(memZero),
    .dmemReq(dmemReq), .dmemReady(dmemReady),
    .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn), .memwbEn(memwbEn),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .exmemFlush(exmemFlush),
    .pcSelBranch(pcSelBranch), .memTimeout(memTimeout),
    .loadUseCnt(loadUseCnt), .branchCnt(branchCnt), .memStallCnt(memStallCnt)
  );

  wire [8:0] ctl = {pcEn, ifidEn, idexEn, exmemEn, memwbEn,
                    ifidFlush, idexFlush, exmemFlush, pcSelBranch};

  localparam logic [8:0] C_RESET  = 9'b00000_111_0;
  localparam logic [8:0] C_FROZEN = 9'b00000_000_0;
  localparam logic [8:0] C_BRANCH = 9'b11111_111_1;
  localparam logic [8:0] C_LDUSE  = 9'b00111_010_0;
  localparam logic [8:0] C_NORMAL = 9'b11111_000_0;

  function automatic bit m_stall();
    return m_wait ? !dmemReady : (dmemReq && !dmemReady);
  endfunction

  function automatic bit m_loaduse();
    return exMemRead && exRd != 0 &&
           ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
  endfunction

  function automatic logic [8:0] exp_ctl();
    if (!rst)             return C_RESET;
    if (m_stall())        return C_FROZEN;
    if (memBranch && memZero) return C_BRANCH;
    if (m_loaduse())      return C_LDUSE;
    return C_NORMAL;
  endfunction

  function automatic logic [31:0] expc(int unsigned v);
`ifdef HAZARD_CTRL_PERF_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_wait = 0; m_wcnt = 0; m_to = 0; m_lu = 0; m_br = 0; m_ms = 0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    if (rst) begin
      if (m_stall())                 m_ms++;
      else if (memBranch && memZero) m_br++;
      else if (m_loaduse())          m_lu++;
      if (m_wait && !dmemReady) begin
        if (m_wcnt < 255) m_wcnt++;
        if (m_wcnt == 255) m_to = 1;
      end else begin
        m_wcnt = 0;
      end
      m_wait = m_stall();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idRs1 = 0; idRs2 = 0; exRd = 0; idUsesRs1 = 0; idUsesRs2 = 0; exMemRead = 0;
    memBranch = 0; memZero = 0; dmemReq = 0; dmemReady = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl: got %b exp %b", ctl, C_RESET); end
    checks++;
    if ({memTimeout, loadUseCnt, branchCnt, memStallCnt} !== 97'd0) begin
      errors++; $display("FAIL reset_regs: got to=%b lu=%0d br=%0d ms=%0d exp all 0",
                         memTimeout, loadUseCnt, branchCnt, memStallCnt);
    end
    tick();
    rst = 1;
    #2;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL reset_release: got %b exp %b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    exMemRead = 1; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
    #2;
    checks++;
    if (ctl !== C_LDUSE) begin errors++; $display("FAIL load_use_ctl: got %b exp %b", ctl, C_LDUSE); end
    tick();
    checks++;
    if (loadUseCnt !== expc(m_lu)) begin
      errors++; $display("FAIL load_use_cnt: got %0d exp %0d", loadUseCnt, expc(m_lu));
    end
    idRs1 = 0; idUsesRs1 = 0; idRs2 = 5; idUsesRs2 = 1;
    #2;
    checks++;
    if (ctl !== C_LDUSE) begin errors++; $display("FAIL load_use_rs2: got %b exp %b", ctl, C_LDUSE); end
    tick();
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    exMemRead = 1; exRd = 0; idRs1 = 0; idUsesRs1 = 1;
    #2;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL zero_reg: got %b exp %b", ctl, C_NORMAL); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    int unsigned base;
    idle_inputs();
    base = m_ms;
    dmemReq = 1;
    for (int i = 0; i < 4; i++) begin
      dmemReady = (i == 3);
      #2;
      checks++;
      if (ctl !== ((i == 3) ? C_NORMAL : C_FROZEN)) begin
        errors++; $display("FAIL mem_wait_c%0d: got %b exp %b", i, ctl,
                           (i == 3) ? C_NORMAL : C_FROZEN);
      end
      tick();
    end
    checks++;
    if (memStallCnt !== expc(base + 3)) begin
      errors++; $display("FAIL mem_wait_cnt: got %0d exp %0d", memStallCnt, expc(base + 3));
    end
    dmemReq = 0;
    #2;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL mem_wait_run: got %b exp %b", ctl, C_NORMAL); end
    tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    memBranch = 1; memZero = 1; exMemRead = 1; exRd = 7; idRs2 = 7; idUsesRs2 = 1;
    dmemReq = 1; dmemReady = 0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (ctl !== C_FROZEN) begin errors++; $display("FAIL prio_frozen%0d: got %b exp %b", i, ctl, C_FROZEN); end
      tick();
    end
    dmemReady = 1;
    #2;
    checks++;
    if (ctl !== C_BRANCH) begin errors++; $display("FAIL prio_branch: got %b exp %b", ctl, C_BRANCH); end
    tick();
    checks++;
    if (branchCnt !== expc(m_br)) begin
      errors++; $display("FAIL prio_branch_cnt: got %0d exp %0d", branchCnt, expc(m_br));
    end
    idle_inputs();
  endtask

  task automatic test_wait_clear();
    // Two long waits that individually stay below the limit must not time out.
    idle_inputs();
    dmemReq = 1;
    for (int k = 0; k < 2; k++) begin
      dmemReady = 0;
      for (int i = 0; i < 200; i++) tick();
      dmemReady = 1;
      tick();
    end
    #2;
    checks++;
    if (memTimeout !== 1'b0) begin errors++; $display("FAIL wait_clear: got %b exp 0", memTimeout); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idRs1     = 5'($urandom_range(0, 3));
      idRs2     = 5'($urandom_range(0, 3));
      exRd      = 5'($urandom_range(0, 3));
      idUsesRs1 = 1'($urandom);
      idUsesRs2 = 1'($urandom);
      exMemRead = 1'($urandom);
      memBranch = ($urandom_range(0, 3) == 0);
      memZero   = 1'($urandom);
      dmemReq   = 1'($urandom);
      dmemReady = ($urandom_range(0, 3) != 0);
      #2;
      checks++;
      if (ctl !== exp_ctl()) begin
        errors++; $display("FAIL random_ctl n=%0d: got %b exp %b", n, ctl, exp_ctl());
      end
      checks++;
      if ({loadUseCnt, branchCnt, memStallCnt} !== {expc(m_lu), expc(m_br), expc(m_ms)}) begin
        errors++; $display("FAIL random_cnt n=%0d: got %0d/%0d/%0d exp %0d/%0d/%0d", n,
                           loadUseCnt, branchCnt, memStallCnt, expc(m_lu), expc(m_br), expc(m_ms));
      end
      tick();
    end
    idle_inputs();
    dmemReady = 1;
    tick();
  endtask

  task automatic test_timeout_reset();
    idle_inputs();
    dmemReq = 1;
    for (int i = 0; i < 300; i++) begin
      #2;
      checks++;
      if (memTimeout !== m_to) begin
        errors++; $display("FAIL timeout_c%0d: got %b exp %b", i, memTimeout, m_to);
      end
      if (i == 300 - 1) begin
        checks++;
        if (ctl !== C_FROZEN) begin errors++; $display("FAIL timeout_frozen: got %b exp %b", ctl, C_FROZEN); end
      end
      tick();
    end
    checks++;
    if (memTimeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b exp 1", memTimeout); end
    #2;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if (ctl !== C_RESET || memTimeout !== 1'b0) begin
      errors++; $display("FAIL async_reset: got ctl=%b to=%b exp ctl=%b to=0", ctl, memTimeout, C_RESET);
    end
    checks++;
    if ({loadUseCnt, branchCnt, memStallCnt} !== 96'd0) begin
      errors++; $display("FAIL async_reset_cnt: got %0d/%0d/%0d exp 0", loadUseCnt, branchCnt, memStallCnt);
    end
    tick();
    rst = 1;
    dmemReady = 1;
    #2;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL after_reset_run: got %b exp %b", ctl, C_NORMAL); end
    tick();
    dmemReq = 0;
    dmemReady = 0;
    #2;
    checks++;
    if (ctl !== C_NORMAL) begin errors++; $display("FAIL after_reset_idle: got %b exp %b", ctl, C_NORMAL); end
    tick();
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_priority();
    test_wait_clear();
    test_random();
    test_timeout_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
